// File: rtl/message_stream_memory.sv
// Multi-channel byte message store with a strobed 32-bit write port and a
// single-byte streaming read-out, one channel/message at a time.
module message_stream_memory #(
    parameter int NUM_CH       = 8,
    parameter int WORDS_PER_CH = 64,
    localparam int BYTES_PER_CH = 4 * WORDS_PER_CH,
    localparam int CW = $clog2(NUM_CH),
    localparam int OW = $clog2(WORDS_PER_CH),
    localparam int LW = $clog2(BYTES_PER_CH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          msg_wr_en,
    input  logic [3:0]    msg_wr_strb,
    input  logic [CW-1:0] msg_channel,
    input  logic [OW-1:0] msg_offset,
    input  logic [31:0]   msg_data,
    input  logic          start,
    input  logic [CW-1:0] start_channel,
    input  logic [LW-1:0] start_len,
    output logic          busy,
    output logic          out_valid,
    output logic [7:0]    out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic          done,
    output logic          err
);

    localparam int DEPTH = NUM_CH * BYTES_PER_CH;

    typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

    state_t        state, state_n;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    rd_data;
    logic [CW-1:0] ch_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx;
    logic [LW-2:0] rd_idx;
    logic          rd_en;
    logic          accept;
    logic          reject;
    logic          advance;
    logic          finish;
    logic          last;

    assign last      = (state == STREAM) && (idx == len_q - LW'(1));
    assign busy      = (state != IDLE);
    assign out_valid = (state == STREAM);
    assign out_data  = rd_data;
    assign out_last  = last;

    // Byte-lane write port; open in every state, no reset on contents.
    always_ff @(posedge clk) begin
        if (msg_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (msg_wr_strb[i])
                    mem[{msg_channel, msg_offset, 2'(i)}] <= msg_data[8*i +: 8];
            end
        end
    end

    // Registered read: holds the byte on stall, old data on same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[{ch_q, rd_idx}];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next-state and datapath control.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        reject  = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        rd_en   = 1'b0;
        rd_idx  = idx[LW-2:0];
        case (state)
            IDLE: begin
                if (start) begin
                    if (start_len != '0 && start_len <= LW'(BYTES_PER_CH)) begin
                        accept  = 1'b1;
                        state_n = FETCH;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            FETCH: begin
                rd_en   = 1'b1;
                state_n = STREAM;
            end
            STREAM: begin
                if (out_ready) begin
                    if (last) begin
                        finish  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        // Last index is len-1, so idx+1 never leaves the channel.
                        advance = 1'b1;
                        rd_en   = 1'b1;
                        rd_idx  = idx[LW-2:0] + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Message context, byte index and one-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_q  <= '0;
            len_q <= '0;
            idx   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= finish;
            err  <= reject;
            if (accept) begin
                ch_q  <= start_channel;
                len_q <= start_len;
                idx   <= '0;
            end else if (advance) begin
                idx <= idx + LW'(1);
            end
        end
    end

endmodule

// File: doc/message_stream_memory.md
MESSAGE_STREAM_MEMORY -- requirements
Module: message_stream_memory

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of message channels (power of 2, >=2).
REQ-002 SHALL have parameter WORDS_PER_CH, default 64, 32-bit words per channel (power of 2); BYTES_PER_CH = 4*WORDS_PER_CH.
REQ-003 SHALL have derived widths CW = $clog2(NUM_CH), OW = $clog2(WORDS_PER_CH), LW = $clog2(BYTES_PER_CH)+1.
REQ-004 One clock; reset is asynchronous and active-high; ports are clk and rst.
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 msg_wr_en  input  1  word write request.
REQ-008 msg_wr_strb  input  4  byte-lane enables; bit i covers msg_data[8i+7:8i].
REQ-009 msg_channel  input  CW  target channel of write.
REQ-010 msg_offset  input  OW  word offset within channel.
REQ-011 msg_data  input  32  write data; lane i stored at byte address 4*msg_offset+i.
REQ-012 start  input  1  request to stream a message (sampled only in IDLE).
REQ-013 start_channel  input  CW  channel to stream.
REQ-014 start_len  input  LW  message length in bytes.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 out_valid / out_data / out_last  output  1 / 8 / 1  byte stream; out_last marks final byte.
REQ-017 out_ready  input  1  downstream accept.
REQ-018 done  output  1  one-cycle pulse after final byte accepted.
REQ-019 err  output  1  one-cycle pulse when start rejected.

Function
REQ-020 Storage SHALL be NUM_CH*BYTES_PER_CH bytes, addressed {channel, offset, lane}; writes SHALL update only lanes with strobe set; msg_wr_en with strobe 0000 SHALL change nothing.
REQ-021 Writes SHALL be accepted every cycle regardless of FSM state, including to the channel being streamed.
REQ-022 Memory read port SHALL be registered (1-cycle read latency); write and read of the same byte in one cycle SHALL return the old value.
REQ-023 FSM states: IDLE, FETCH, STREAM; DONE is not a state, done is a pulse on the STREAM->IDLE transition.
REQ-024 IDLE: start with 1 <= start_len <= BYTES_PER_CH SHALL latch channel/length, set byte index 0, go FETCH.
REQ-025 IDLE: start with start_len = 0 or > BYTES_PER_CH SHALL pulse err next cycle, stay IDLE.
REQ-026 FETCH: issue read of byte index 0; next cycle go STREAM with out_valid=1 (first byte valid 2 cycles after start sampled).
REQ-027 STREAM: out_data, out_last SHALL be stable while out_valid && !out_ready; value is memory content at the cycle the read was issued.
REQ-028 STREAM: on out_valid && out_ready with index < len-1, SHALL advance index and present the next byte the following cycle (1 byte/cycle under continuous out_ready).
REQ-029 out_last SHALL be 1 exactly when index = len-1.
REQ-030 On handshake with out_last=1: out_valid drops next cycle, done pulses next cycle, FSM returns IDLE; start in that IDLE cycle is honoured.
REQ-031 start while busy SHALL be ignored (no err, no effect).
REQ-032 Byte index arithmetic SHALL not wrap: len = BYTES_PER_CH streams bytes 0..BYTES_PER_CH-1 and stops.

Reset
REQ-033 rst SHALL immediately force IDLE; busy, out_valid, out_data, out_last, done, err = 0; index and latched length = 0.
REQ-034 Memory contents SHALL NOT be cleared by rst; reset mid-stream SHALL abort without done.
REQ-035 First start after rst deassertion SHALL be sampled no earlier than the first rising clk edge with rst low.

Verification
REQ-036 Write ch3 off0 data 0x44332211 strb 1111, then off0 data 0xAABBCCDD strb 0101 -> bytes 0..3 of ch3 = DD,22,BB,44.
REQ-037 start ch3 len 4, out_ready=1 -> out_valid from cycle +2, bytes DD,22,BB,44 on 4 consecutive cycles, out_last on 4th, done pulse cycle after.
REQ-038 Same stream with out_ready toggling 1,0,0,1,... -> each byte held stable while stalled, order unchanged, exactly 4 handshakes.
REQ-039 start len 0 and len 257 (defaults) -> err pulse each, busy stays 0; start len 256 -> 256 bytes, out_last only on byte 255.
REQ-040 Assert rst during 2nd byte of a stream -> outputs 0 asynchronously, no done; restart reads unchanged memory contents.
REQ-041 Write byte 2 of streaming channel in cycle its read is issued -> old value streamed; subsequent stream returns new value.
